// File: rtl/scroll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scroll_pkg
// Description : Shared defaults and packed-lane slice helpers for the
//               horizontal lane scroller and its move-timer.
//               Optional feature macro used by the scroller: SCROLL_SPEEDUP_EN
// Revision    : 1.0 - initial release
// ============================================================================
package scroll_pkg;

    // Screen / timing defaults (25 MHz pixel clock, 640-pixel visible line)
    localparam int SCREEN_W_DEFAULT     = 640;
    localparam int BASE_PERIOD_DEFAULT  = 100000;
    localparam int MIN_PERIOD_DEFAULT   = 20000;

    // Packed-lane field widths
    localparam int LANES_DEFAULT        = 4;
    localparam int POS_W_DEFAULT        = 10;
    localparam int STEP_W_DEFAULT       = 3;
    localparam int CTR_W_DEFAULT        = 18;
    localparam int SCORE_W_DEFAULT      = 7;
    localparam int SCORE_SHIFT_DEFAULT  = 9;
    localparam int INIT_SPACING_DEFAULT = 160;

    // LSB of lane 'lane' inside a bus built from fields of 'width' bits
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage : scroll_pkg
`default_nettype wire

// File: rtl/scroll_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : scroll_tick_gen
// Description : Score-accelerated move timer. Emits a one-cycle combinational
//               tick strobe in the cycle the timer reaches period-1; the
//               consumer registers its outputs on that same edge, so the
//               first tick lands exactly 'period' cycles after reset.
//               Reusable for vertical scrollers.
//               Macro SCROLL_SPEEDUP_EN: when defined the period shrinks with
//               score; otherwise it is fixed at BASE_PERIOD.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               i_enable - 1 = timer counts, 0 = timer holds, no tick
//               i_score  - current score
//               o_tick   - move strobe (one cycle per period)
// Revision    : 1.0 - initial release
// ============================================================================
module scroll_tick_gen
    import scroll_pkg::*;
#(
    parameter int CTR_W       = CTR_W_DEFAULT,
    parameter int BASE_PERIOD = BASE_PERIOD_DEFAULT,
    parameter int MIN_PERIOD  = MIN_PERIOD_DEFAULT,
    parameter int SCORE_W     = SCORE_W_DEFAULT,
    parameter int SCORE_SHIFT = SCORE_SHIFT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic [SCORE_W-1:0] i_score,
    output logic               o_tick
);

    localparam logic [CTR_W:0]   c_base    = (CTR_W+1)'(BASE_PERIOD);
    localparam logic [CTR_W:0]   c_min     = (CTR_W+1)'(MIN_PERIOD);
    localparam logic [CTR_W:0]   c_one     = (CTR_W+1)'(1);
    localparam logic [CTR_W-1:0] c_tmr_one = (CTR_W)'(1);

    logic [CTR_W:0]   w_period;
    logic [CTR_W-1:0] timer_q;
    logic [CTR_W-1:0] timer_d;

`ifdef SCROLL_SPEEDUP_EN
    logic [CTR_W:0] w_reduction;
    logic [CTR_W:0] w_diff;

    // Subtraction is done one bit wider than the timer; a reduction larger
    // than the base period would wrap, so it is caught before subtracting.
    always_comb begin
        w_reduction = (CTR_W+1)'(i_score) << SCORE_SHIFT;
        w_diff      = c_base - w_reduction;
        if (w_reduction > c_base || w_diff < c_min) begin
            w_period = c_min;
        end else begin
            w_period = w_diff;
        end
    end
`else
    logic unused_score;

    assign unused_score = ^i_score;

    always_comb begin
        w_period = c_base;
    end
`endif

    // '>=' rather than '==' so a mid-count score rise that pulls period-1
    // below the current count fires on the very next edge instead of
    // letting the timer run the full width.
    always_comb begin
        timer_d = timer_q;
        o_tick  = 1'b0;
        if (i_enable) begin
            if ({1'b0, timer_q} >= (w_period - c_one)) begin
                o_tick  = 1'b1;
                timer_d = '0;
            end else begin
                timer_d = timer_q + c_tmr_one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule : scroll_tick_gen
`default_nettype wire

// File: rtl/lane_scroller.sv
`default_nettype none
// ============================================================================
// Module      : lane_scroller
// Description : Multi-lane horizontal obstacle scroller. One shared move
//               timer drives LANES position registers, each with its own
//               step and direction, wrapping modulo SCREEN_W.
//               Macro SCROLL_SPEEDUP_EN: when defined the move period
//               shortens with score; otherwise score is ignored.
// Ports       : clk        - system clock (25 MHz pixel clock)
//               rst_n      - asynchronous active-low reset
//               enable     - 1 = scrolling runs, 0 = timer/positions freeze
//               score      - current score
//               lane_dir   - per lane 1 = right, 0 = left
//               lane_step  - per-lane step, lane i at [i*STEP_W +: STEP_W]
//               h_pos      - per-lane x position, lane i at [i*POS_W +: POS_W]
//               move_tick  - one-cycle pulse on every move
//               lane_wrap  - one-cycle per-lane wrap pulse on a move
// Revision    : 1.0 - initial release
// ============================================================================
module lane_scroller
    import scroll_pkg::*;
#(
    parameter int LANES        = LANES_DEFAULT,
    parameter int POS_W        = POS_W_DEFAULT,
    parameter int SCREEN_W     = SCREEN_W_DEFAULT,
    parameter int STEP_W       = STEP_W_DEFAULT,
    parameter int CTR_W        = CTR_W_DEFAULT,
    parameter int BASE_PERIOD  = BASE_PERIOD_DEFAULT,
    parameter int MIN_PERIOD   = MIN_PERIOD_DEFAULT,
    parameter int SCORE_W      = SCORE_W_DEFAULT,
    parameter int SCORE_SHIFT  = SCORE_SHIFT_DEFAULT,
    parameter int INIT_SPACING = INIT_SPACING_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [SCORE_W-1:0]      score,
    input  logic [LANES-1:0]        lane_dir,
    input  logic [LANES*STEP_W-1:0] lane_step,
    output logic [LANES*POS_W-1:0]  h_pos,
    output logic                    move_tick,
    output logic [LANES-1:0]        lane_wrap
);

    localparam logic [POS_W:0] c_screen = (POS_W+1)'(SCREEN_W);

    logic w_tick;
    logic move_tick_q;
    logic move_tick_d;

    scroll_tick_gen #(
        .CTR_W       (CTR_W),
        .BASE_PERIOD (BASE_PERIOD),
        .MIN_PERIOD  (MIN_PERIOD),
        .SCORE_W     (SCORE_W),
        .SCORE_SHIFT (SCORE_SHIFT)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (enable),
        .i_score  (score),
        .o_tick   (w_tick)
    );

    // Registered alongside the positions so sprite logic sees tick, wrap
    // and new position change on the same edge.
    always_comb begin
        move_tick_d = w_tick;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_tick_q <= 1'b0;
        end else begin
            move_tick_q <= move_tick_d;
        end
    end

    assign move_tick = move_tick_q;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            localparam int             c_pos_lsb  = lane_lsb(i, POS_W);
            localparam int             c_step_lsb = lane_lsb(i, STEP_W);
            localparam logic [POS_W-1:0] c_pos_rst =
                POS_W'((i * INIT_SPACING) % SCREEN_W);

            logic [POS_W-1:0] pos_q;
            logic [POS_W-1:0] pos_d;
            logic             wrap_q;
            logic             wrap_d;
            logic [POS_W:0]   w_step;
            logic [POS_W:0]   w_pos;
            logic [POS_W:0]   w_sum;

            // Direction and step are only looked at under w_tick, so changes
            // between moves have no effect until the next move.
            always_comb begin
                w_step = (POS_W+1)'(lane_step[c_step_lsb +: STEP_W]);
                w_pos  = {1'b0, pos_q};
                w_sum  = w_pos + w_step;
                pos_d  = pos_q;
                wrap_d = 1'b0;
                if (w_tick) begin
                    if (lane_dir[i]) begin
                        if (w_sum >= c_screen) begin
                            pos_d  = POS_W'(w_sum - c_screen);
                            wrap_d = 1'b1;
                        end else begin
                            pos_d  = w_sum[POS_W-1:0];
                        end
                    end else begin
                        // pos < step cannot hit for step 0, so a zero step
                        // simply holds without wrapping.
                        if (w_pos < w_step) begin
                            pos_d  = POS_W'(w_pos + c_screen - w_step);
                            wrap_d = 1'b1;
                        end else begin
                            pos_d  = POS_W'(w_pos - w_step);
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pos_q  <= c_pos_rst;
                    wrap_q <= 1'b0;
                end else begin
                    pos_q  <= pos_d;
                    wrap_q <= wrap_d;
                end
            end

            assign h_pos[c_pos_lsb +: POS_W] = pos_q;
            assign lane_wrap[i]              = wrap_q;
        end
    endgenerate

endmodule : lane_scroller
`default_nettype wire

// File: tb/tb_lane_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_scroller
// Description : Scoreboard bench for lane_scroller. Stimulus pushes the
//               expected (cycle, positions, wraps) of every move into a
//               queue; a monitor pops and compares on each move_tick.
//               Expectations follow SCROLL_SPEEDUP_EN if it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_scroller;

    localparam int LANES    = 4;
    localparam int POS_W    = 10;
    localparam int STEP_W   = 3;
    localparam int SCREEN_W = 640;
    localparam int CTR_W    = 18;
    localparam int BASE     = 20;
    localparam int MINP     = 5;
    localparam int SCORE_W  = 7;
    localparam int SHIFT    = 1;
    localparam int SPACING  = 160;

`ifdef SCROLL_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic                    clk;
    logic                    rst_n;
    logic                    enable;
    logic [SCORE_W-1:0]      score;
    logic [LANES-1:0]        lane_dir;
    logic [LANES*STEP_W-1:0] lane_step;
    logic [LANES*POS_W-1:0]  h_pos;
    logic                    move_tick;
    logic [LANES-1:0]        lane_wrap;

    lane_scroller #(
        .LANES        (LANES),
        .POS_W        (POS_W),
        .SCREEN_W     (SCREEN_W),
        .STEP_W       (STEP_W),
        .CTR_W        (CTR_W),
        .BASE_PERIOD  (BASE),
        .MIN_PERIOD   (MINP),
        .SCORE_W      (SCORE_W),
        .SCORE_SHIFT  (SHIFT),
        .INIT_SPACING (SPACING)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .score     (score),
        .lane_dir  (lane_dir),
        .lane_step (lane_step),
        .h_pos     (h_pos),
        .move_tick (move_tick),
        .lane_wrap (lane_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since the last rst_n release (value k after the k-th edge)
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int                     cyc;
        logic [LANES*POS_W-1:0] pos;
        logic [LANES-1:0]       wrap;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   failures;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [LANES*POS_W-1:0] pack4(input int l3, input int l2,
                                                     input int l1, input int l0);
        return {10'(l3), 10'(l2), 10'(l1), 10'(l0)};
    endfunction

    task automatic push(input int c, input logic [LANES*POS_W-1:0] p, input logic [LANES-1:0] w);
        exp_t e;
        e.cyc  = c;
        e.pos  = p;
        e.wrap = w;
        sb_q.push_back(e);
    endtask

    task automatic set_step(input int lane, input int val);
        lane_step[lane*STEP_W +: STEP_W] = 3'(val);
    endtask

    // Advance to the falling edge at which cyc == n (bounded)
    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        @(negedge clk);
        while (cyc != n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            checks++;
            failures++;
            $display("FAIL wait_cyc: timed out at cyc=%0d waiting for %0d", cyc, n);
        end
    endtask

    // Monitor: every presented move must match the head of the scoreboard
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && move_tick) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tick: got tick at cyc=%0d h_pos=0x%0h expected none",
                         cyc, h_pos);
            end else begin
                e = sb_q.pop_front();
                check("tick_cycle", 64'(cyc), 64'(e.cyc));
                check("tick_h_pos", 64'(h_pos), 64'(e.pos));
                check("tick_lane_wrap", 64'(lane_wrap), 64'(e.wrap));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int p5;
        int p100;
        int first;
        int stp;
        int l0, l1, l2;
        int guard;
        logic w0, w1;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        enable    = 1'b1;
        score     = '0;
        // lane0 left 2, lane1 left 7, lane2 right 7, lane3 left 0
        lane_dir  = 4'b0100;
        lane_step = {3'd0, 3'd7, 3'd7, 3'd2};

        repeat (3) @(negedge clk);
        check("reset_h_pos", 64'(h_pos), 64'(pack4(480, 320, 160, 0)));
        check("reset_move_tick", 64'(move_tick), 64'd0);
        check("reset_lane_wrap", 64'(lane_wrap), 64'd0);

        // Phase 1: period 20 from reset; lane0 wraps left then right,
        // lane1 walks down to 1 and wraps left, lane2 steps right.
        for (int n = 1; n <= 24; n++) begin
            l0 = (n == 1) ? 638 : 0;
            w0 = (n <= 2);
            l1 = (n <= 22) ? (160 - 7 * n) : ((n == 23) ? 1 : 638);
            w1 = (n == 24);
            l2 = 320 + 7 * n;
            push(20 * n, pack4(480, l2, l1, l0), {2'b00, w1, w0});
        end
        rst_n = 1'b1;
        wait_cyc(30);  lane_dir = 4'b0101;
        wait_cyc(50);  set_step(0, 0);
        wait_cyc(450); set_step(1, 5);
        wait_cyc(470); set_step(1, 3);
        wait_cyc(480);
        lane_step = '0;
        t = 480;

        // Phase 2: score-driven period with all lanes holding at step 0
        p5    = SPEEDUP ? 10 : 20;
        p100  = SPEEDUP ? 5 : 20;
        score = 7'd5;
        for (int k = 1; k <= 3; k++) push(t + k * p5, pack4(480, 488, 638, 0), 4'b0000);
        t = t + 3 * p5;
        wait_cyc(t);
        score = 7'd100;
        for (int k = 1; k <= 3; k++) push(t + k * p100, pack4(480, 488, 638, 0), 4'b0000);
        t = t + 3 * p100;
        wait_cyc(t);
        score = 7'd0;

        // Score 0 -> 8 with timer at 15: period 4 fires on the next edge
        first = SPEEDUP ? 16 : 20;
        stp   = SPEEDUP ? 4 : 20;
        for (int k = 0; k < 3; k++) push(t + first + k * stp, pack4(480, 488, 638, 0), 4'b0000);
        wait_cyc(t + 15);
        score = 7'd8;
        t = t + first + 2 * stp;
        wait_cyc(t);
        score = 7'd0;

        // Phase 3: enable low for 50 cycles with the timer at 7
        set_step(3, 1);
        push(t + 70, pack4(479, 488, 638, 0), 4'b0000);
        push(t + 90, pack4(478, 488, 638, 0), 4'b0000);
        wait_cyc(t + 7);
        enable = 1'b0;
        wait_cyc(t + 30);
        check("frozen_h_pos_mid", 64'(h_pos), 64'(pack4(480, 488, 638, 0)));
        wait_cyc(t + 57);
        check("frozen_h_pos_end", 64'(h_pos), 64'(pack4(480, 488, 638, 0)));
        enable = 1'b1;
        t = t + 90;
        wait_cyc(t);

        // Phase 4: reset asserted in the cycle that would tick
        wait_cyc(t + 19);
        rst_n = 1'b0;
        #1;
        check("midrst_h_pos", 64'(h_pos), 64'(pack4(480, 320, 160, 0)));
        check("midrst_move_tick", 64'(move_tick), 64'd0);
        check("midrst_lane_wrap", 64'(lane_wrap), 64'd0);
        push(20, pack4(479, 320, 160, 0), 4'b0000);
        push(40, pack4(478, 320, 160, 0), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(40);

        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_lane_scroller
`default_nettype wire
